// File: rtl/booth_multiplier.sv
// ============================================================================
// Module   : booth_multiplier
// Purpose  : Iterative 32x32 signed multiplier, radix-2 Booth recoding.
//            One add/subtract/shift step per clock, 32 steps per operation.
//            Returns the low 32 bits of the product and a signed-overflow
//            flag, announced by a one-cycle ready pulse.
// Ports    :
//   clock           in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   ctrl_MULT       in   start request, honoured only while not busy
//   data_operandA   in   [31:0] multiplicand (two's complement)
//   data_operandB   in   [31:0] multiplier (two's complement)
//   data_result     out  [31:0] low word of A*B, held until next completion
//   data_exception  out  signed overflow of the 32-bit result
//   data_resultRDY  out  one-cycle completion pulse
//   busy            out  high while an operation is in flight
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_multiplier (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [5:0] LAST_STEP = 6'd31;

  logic [0:0]  state;
  logic [32:0] mcand;
  logic [32:0] acc;
  logic [31:0] mplier;
  logic        q_1;
  logic [5:0]  count;

  // Booth step datapath
  logic [32:0] addend;
  logic        carry_in;
  logic [32:0] sum;
  logic [32:0] acc_next;
  logic [31:0] mplier_next;
  logic [32:0] prod_hi;
  logic        overflow;

  // Subtraction is acc + ~mcand + 1, so the adder is shared by both cases.
  always_comb begin
    addend   = 33'd0;
    carry_in = 1'b0;
    case ({mplier[0], q_1})
      2'b01: addend = mcand;
      2'b10: begin
        addend   = ~mcand;
        carry_in = 1'b1;
      end
      default: addend = 33'd0;
    endcase
  end

  assign sum = acc + addend + {32'd0, carry_in};

  // Arithmetic right shift of {sum, mplier, q_1}; the sign of the 33-bit
  // sum is replicated so the most negative multiplicand stays exact.
  assign acc_next    = {sum[32], sum[32:1]};
  assign mplier_next = {sum[0], mplier[31:1]};

  // After the final step the 64-bit product is {acc_next[31:0], mplier_next}.
  // The low word is representable only if bits 63..31 are a pure sign fill.
  assign prod_hi  = {acc_next[31:0], mplier_next[31]};
  assign overflow = !((prod_hi == 33'd0) || (prod_hi == {33{1'b1}}));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      mcand          <= 33'd0;
      acc            <= 33'd0;
      mplier         <= 32'd0;
      q_1            <= 1'b0;
      count          <= 6'd0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (state == IDLE) begin
        if (ctrl_MULT) begin
          mcand  <= {data_operandA[31], data_operandA};
          acc    <= 33'd0;
          mplier <= data_operandB;
          q_1    <= 1'b0;
          count  <= 6'd0;
          busy   <= 1'b1;
          state  <= RUN;
        end
      end else begin
        acc    <= acc_next;
        mplier <= mplier_next;
        q_1    <= mplier[0];
        count  <= count + 6'd1;
        if (count == LAST_STEP) begin
          data_result    <= mplier_next;
          data_exception <= overflow;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_multiplier.sv
// ============================================================================
// Module   : tb_booth_multiplier
// Purpose  : Self-checking bench for booth_multiplier. Directed vectors with
//            hand-computed products, start-while-busy, back-to-back starts,
//            mid-operation asynchronous reset, and random signed pairs
//            against a 64-bit arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_multiplier;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks;
  int errors;

  booth_multiplier dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Issue one operation and check latency, pulse width, result and flag.
  task automatic do_mult(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_exc);
    int edges;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    // Operands are captured already; scrambling them must not matter.
    data_operandA = ~a;
    data_operandB = ~b;
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    edges = 0;
    while (!data_resultRDY && edges < 40) begin
      @(negedge clock);
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'd32);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_result"}, 64'(data_result), 64'(exp_res));
    check({tag, "_exc"}, 64'(data_exception), 64'(exp_exc));
    @(negedge clock);
    check({tag, "_rdy_width"}, 64'(data_resultRDY), 64'd0);
    check({tag, "_hold"}, 64'(data_result), 64'(exp_res));
  endtask

  initial begin
    int edges;
    int gap;
    int pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    longint      prod;
    logic [63:0] p;
    logic        rexc;

    checks        = 0;
    errors        = 0;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    reset_n       = 1'b1;
    #1 reset_n    = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;

    // Directed vectors
    do_mult("3x5",      32'd3,          32'd5,          32'h0000000F, 1'b0);
    do_mult("m7x6",     32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0);
    do_mult("min_x1",   32'h80000000,   32'd1,          32'h80000000, 1'b0);
    do_mult("min_xm1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1);
    do_mult("max_x2",   32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE, 1'b1);
    do_mult("2p16sq",   32'h00010000,   32'h00010000,   32'h00000000, 1'b1);

    // Start while busy is ignored; held start begins a new op at E33.
    @(negedge clock);
    data_operandA = 32'd4;
    data_operandB = 32'd4;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    repeat (9) @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT     = 1'b1;
    edges = 9;
    while (!data_resultRDY && edges < 40) begin
      @(negedge clock);
      edges++;
    end
    check("busy_ign_latency", 64'(edges), 64'd32);
    check("busy_ign_result", 64'(data_result), 64'h10);
    check("busy_ign_exc", 64'(data_exception), 64'd0);
    gap = 0;
    @(negedge clock);
    gap++;
    check("b2b_busy", 64'(busy), 64'd1);
    while (!data_resultRDY && gap < 40) begin
      @(negedge clock);
      gap++;
    end
    ctrl_MULT = 1'b0;
    check("b2b_gap", 64'(gap), 64'd33);
    check("b2b_result", 64'(data_result), 64'h51);
    @(negedge clock);

    // Asynchronous reset in the middle of an operation.
    data_operandA = 32'd100;
    data_operandB = 32'd100;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    repeat (14) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_result", 64'(data_result), 64'd0);
    check("arst_exc", 64'(data_exception), 64'd0);
    check("arst_rdy", 64'(data_resultRDY), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    check("arst_no_rdy", 64'(pulses), 64'd0);
    do_mult("2xm3", 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0);

    // Random signed pairs against a 64-bit reference product.
    for (int n = 0; n < 1000; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      // Mix in small magnitudes so non-overflow results appear often.
      if (n % 3 == 0) ra = {{16{ra[31]}}, ra[15:0]};
      if (n % 3 == 0) rb = {{16{rb[31]}}, rb[15:0]};
      prod = longint'($signed(ra)) * longint'($signed(rb));
      p    = 64'(prod);
      rexc = !((p[63:31] == 33'd0) || (p[63:31] == {33{1'b1}}));
      do_mult("rand", ra, rb, p[31:0], rexc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
